// File: rtl/score_pkg.sv
// Shared types and seven-segment constants for the score counter and its HEX encoders.
package score_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low {g,f,e,d,c,b,a} codes for numerals 0..9.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_encode.sv
// One BCD digit to an active-low seven-segment pattern; non-decimal values and the blank flag show nothing.
module seg7_encode
  import score_pkg::*;
(
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit < 4'd10)) seg = SEG_LUT[digit];
  end

endmodule

// File: rtl/score_encoder.sv
// BCD game-score counter with best-score register and registered HEX display drive.
// Build option SCORE_LEADING_BLANK_EN blanks leading zero digits above digit 0.
module score_encoder
  import score_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    restart,
  input  logic                    freeze,
  input  logic                    show_best,
  output logic [4*DIGITS-1:0]     score_bcd,
  output logic [4*DIGITS-1:0]     best_bcd,
  output logic [DIGITS-1:0][6:0]  HEXout,
  output logic                    maxed
);

  logic                   inc_q, inc_d;
  logic                   freeze_q, freeze_d;
  logic [4*DIGITS-1:0]    score_q, score_d;
  logic [4*DIGITS-1:0]    best_q, best_d;
  logic [DIGITS-1:0][6:0] hex_q, hex_d;

  logic                   inc_fire;
  logic                   freeze_rise;
  logic [4*DIGITS-1:0]    score_inc;
  logic [4*DIGITS-1:0]    disp;
  logic [DIGITS-1:0]      blank;
  logic                   carry;
  logic                   lead_zero;

  always_comb begin
    inc_d       = inc;
    freeze_d    = freeze;
    inc_fire    = inc & ~inc_q & ~freeze & ~restart;
    freeze_rise = freeze & ~freeze_q;

    maxed = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) maxed = 1'b0;
    end

    // Ripple a +1 through the digits; a 9 rolls to 0 and passes the carry on.
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end

    score_d = score_q;
    if (restart)                score_d = '0;
    else if (inc_fire && !maxed) score_d = score_inc;

    // Packed BCD with valid digits orders the same as the numbers it holds.
    best_d = best_q;
    if (freeze_rise && (score_q > best_q)) best_d = score_q;

    disp = show_best ? best_q : score_q;

    blank     = '0;
    lead_zero = 1'b1;
`ifdef SCORE_LEADING_BLANK_EN
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero = lead_zero & (disp[4*i +: 4] == 4'd0);
      blank[i]  = lead_zero;
    end
`else
    lead_zero = 1'b0;
`endif
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_encode u_seg (
      .digit (disp[4*g +: 4]),
      .blank (blank[g]),
      .seg   (hex_d[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q    <= 1'b0;
      freeze_q <= 1'b0;
      score_q  <= '0;
      best_q   <= '0;
      for (int i = 0; i < DIGITS; i++) hex_q[i] <= SEG_LUT[0];
    end else begin
      inc_q    <= inc_d;
      freeze_q <= freeze_d;
      score_q  <= score_d;
      best_q   <= best_d;
      hex_q    <= hex_d;
    end
  end

  assign score_bcd = score_q;
  assign best_bcd  = best_q;
  assign HEXout    = hex_q;

endmodule

// File: tb/tb_score_encoder.sv
// Bench for score_encoder: integer reference model of score/best/display, directed steps then random traffic.
module tb_score_encoder;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 10 ** DIGITS - 1;

  typedef logic [DIGITS-1:0][6:0] hex_t;

  logic         clk = 1'b0;
  logic         reset, inc, restart, freeze, show_best;
  logic [W-1:0] score_bcd, best_bcd;
  hex_t         HEXout;
  logic         maxed;

  always #5 clk = ~clk;

  score_encoder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .restart   (restart),
    .freeze    (freeze),
    .show_best (show_best),
    .score_bcd (score_bcd),
    .best_bcd  (best_bcd),
    .HEXout    (HEXout),
    .maxed     (maxed)
  );

  int vectors = 0;
  int miscompares = 0;

  int   m_score, m_best, m_disp;
  bit   m_incp, m_frzp;
  hex_t m_hex;

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Comparator-side decode: blank reads as 0, unknown code as -1.
  function automatic int decode(logic [6:0] c);
    for (int d = 0; d < 10; d++) if (c === seg_of(d)) return d;
    if (c === 7'b1111111) return 0;
    return -1;
  endfunction

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic hex_t hex_of(int v);
    hex_t h;
    for (int i = 0; i < DIGITS; i++) begin
      h[i] = seg_of((v / (10 ** i)) % 10);
`ifdef SCORE_LEADING_BLANK_EN
      if (i > 0 && v < 10 ** i) h[i] = 7'b1111111;
`endif
    end
    return h;
  endfunction

  task automatic check32(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    check32({tag, ".score"}, 32'(score_bcd), 32'(to_bcd(m_score)));
    check32({tag, ".best"},  32'(best_bcd),  32'(to_bcd(m_best)));
    check32({tag, ".maxed"}, 32'(maxed),     32'(m_score == MAXV));
    check32({tag, ".hex"},   32'(HEXout),    32'(m_hex));
    for (int i = 0; i < DIGITS; i++)
      check32({tag, ".readback"}, 32'(decode(HEXout[i])), 32'((m_disp / (10 ** i)) % 10));
  endtask

  task automatic cycle(bit i_inc, bit i_restart, bit i_freeze, bit i_show, bit i_reset = 1'b0);
    bit fire;
    inc = i_inc; restart = i_restart; freeze = i_freeze; show_best = i_show; reset = i_reset;
    @(posedge clk);
    if (i_reset) begin
      m_score = 0; m_best = 0; m_incp = 0; m_frzp = 0; m_disp = 0;
      m_hex = {DIGITS{7'b1000000}};
    end else begin
      m_disp = i_show ? m_best : m_score;
      m_hex  = hex_of(m_disp);
      fire   = i_inc && !m_incp && !i_freeze && !i_restart;
      if (i_freeze && !m_frzp && m_score > m_best) m_best = m_score;
      if (i_restart)                   m_score = 0;
      else if (fire && m_score < MAXV) m_score = m_score + 1;
      m_incp = i_inc;
      m_frzp = i_freeze;
    end
    #1;
    check_all("step");
  endtask

  task automatic pulses(int n, bit f, bit s);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 1'b0, f, s);
      cycle(1'b0, 1'b0, f, s);
    end
  endtask

  initial begin
    inc = 0; restart = 0; freeze = 0; show_best = 0; reset = 1;
    m_score = 0; m_best = 0; m_incp = 0; m_frzp = 0; m_disp = 0;
    m_hex = {DIGITS{7'b1000000}};

    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check32("reset.hex",   32'(HEXout),    32'({7'b1000000, 7'b1000000}));
    check32("reset.score", 32'(score_bcd), 32'h0);

    pulses(12, 0, 0);
    check32("count12.score", 32'(score_bcd), 32'h12);
    check32("count12.hex",   32'(HEXout),    32'({7'b1111001, 7'b0100100}));

    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check32("held.score", 32'(score_bcd), 32'h13);

    cycle(0, 1, 0, 0);
    pulses(100, 0, 0);
    check32("sat.score", 32'(score_bcd), 32'h99);
    check32("sat.maxed", 32'(maxed),     32'h1);
    pulses(1, 0, 0);
    check32("sat101.score", 32'(score_bcd), 32'h99);

    cycle(0, 1, 0, 0);
    pulses(23, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    check32("best23", 32'(best_bcd), 32'h23);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    pulses(5, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check32("best_kept", 32'(best_bcd), 32'h23);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check32("show_best.hex", 32'(HEXout), 32'({7'b0100100, 7'b0110000}));

    cycle(1, 1, 0, 0);
    check32("restart_wins", 32'(score_bcd), 32'h0);
    cycle(0, 0, 0, 0);
    pulses(3, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check32("frozen_edge_lost", 32'(score_bcd), 32'h03);
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 0);

    pulses(4, 0, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check32("mid_reset.best", 32'(best_bcd), 32'h0);

    pulses(7, 0, 0);
`ifdef SCORE_LEADING_BLANK_EN
    check32("score7.hex1", 32'(HEXout[1]), 32'(7'b1111111));
`else
    check32("score7.hex1", 32'(HEXout[1]), 32'(7'b1000000));
`endif
    check32("score7.hex0", 32'(HEXout[0]), 32'(7'b1111000));

    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
